// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Next program counter, wrapping modulo 2^width.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc, input int width);
    return (pc + 32'd1) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_out_stage.sv
// One-entry valid/ready register holding the fetched instruction and its address.
module fetch_out_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc
);

  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc;

  // Flush beats load; the payload is kept when the entry is dropped or consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= {DATA_W{1'b0}};
      r_pc    <= {ADDR_W{1'b0}};
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_data;
      r_pc    <= i_pc;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch sequencer: owns the pc, drives the instruction memory address and
// hands instructions to decode through a one-entry output stage.
module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_FETCH = 0,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_halt_req,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_fetch_count
);

  localparam logic [CNT_W:0]   LP_MAX = (CNT_W + 1)'(MAX_FETCH);
  localparam logic [CNT_W-1:0] LP_SAT = {CNT_W{1'b1}};

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_count;
  logic              r_halted;

  logic w_xfer;
  logic w_budget_hit;
  logic w_load;
  logic w_clear;

  always_comb begin
    w_xfer       = o_instr_valid && i_instr_ready;
    w_budget_hit = 1'b0;
    // The accepted word that reaches the budget stops fetching in the same cycle.
    if ((MAX_FETCH != 0) && (r_state == ST_FETCH) && w_xfer && !i_redirect_valid &&
        (({1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1}) == LP_MAX)) begin
      w_budget_hit = 1'b1;
    end else begin
      w_budget_hit = 1'b0;
    end
    w_load  = (r_state == ST_FETCH) && !i_redirect_valid && !i_halt_req && !w_budget_hit &&
              (!o_instr_valid || i_instr_ready);
    w_clear = w_xfer && !w_load;
  end

  // Sequencer state and the registered halted flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!i_halt_req && i_start) begin
            r_state <= ST_FETCH;
          end
          r_halted <= 1'b0;
        end
        ST_FETCH: begin
          if (i_halt_req || w_budget_hit) begin
            r_state <= ST_DRAIN;
          end
          r_halted <= 1'b0;
        end
        ST_DRAIN: begin
          if (!o_instr_valid || i_instr_ready) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_halted <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (!i_halt_req && i_start) begin
            r_state  <= ST_FETCH;
            r_halted <= 1'b0;
          end else begin
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Program counter: a redirect overrides any fetch advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= {ADDR_W{1'b0}};
    end else if (i_redirect_valid) begin
      r_pc <= i_redirect_addr;
    end else if (w_load) begin
      r_pc <= ADDR_W'(pc_inc(32'(r_pc), ADDR_W));
    end else begin
      r_pc <= r_pc;
    end
  end

  // Saturating count of accepted words; a word dropped by redirect is not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= {CNT_W{1'b0}};
    end else if (w_xfer && !i_redirect_valid && (r_count != LP_SAT)) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  fetch_out_stage #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_out_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_flush (i_redirect_valid),
    .i_clear (w_clear),
    .i_data  (i_mem_data),
    .i_pc    (r_pc),
    .o_valid (o_instr_valid),
    .o_instr (o_instr),
    .o_pc    (o_instr_pc)
  );

  assign o_mem_addr    = r_pc;
  assign o_halted      = r_halted;
  assign o_fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed vector tables plus randomized
// traffic against a behavioural model, on an unlimited and a budget-3 instance.
module tb_instr_fetch_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, halt_req, redir, ready;
  logic [1:0] raddr;
  logic [1:0] mem [4];

  logic [1:0] a_maddr, a_mdata, a_instr, a_ipc;
  logic [1:0] b_maddr, b_mdata, b_instr, b_ipc;
  logic       a_valid, a_halted, b_valid, b_halted;
  logic [7:0] a_cnt, b_cnt;

  assign a_mdata = mem[a_maddr];
  assign b_mdata = mem[b_maddr];

  instr_fetch_sequencer #(.ADDR_W(2), .DATA_W(2), .MAX_FETCH(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt_req(halt_req),
    .i_redirect_valid(redir), .i_redirect_addr(raddr), .o_mem_addr(a_maddr),
    .i_mem_data(a_mdata), .o_instr_valid(a_valid), .i_instr_ready(ready),
    .o_instr(a_instr), .o_instr_pc(a_ipc), .o_halted(a_halted), .o_fetch_count(a_cnt));

  instr_fetch_sequencer #(.ADDR_W(2), .DATA_W(2), .MAX_FETCH(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt_req(halt_req),
    .i_redirect_valid(redir), .i_redirect_addr(raddr), .o_mem_addr(b_maddr),
    .i_mem_data(b_mdata), .o_instr_valid(b_valid), .i_instr_ready(ready),
    .o_instr(b_instr), .o_instr_pc(b_ipc), .o_halted(b_halted), .o_fetch_count(b_cnt));

  typedef struct {
    logic       rst_n, start, halt, redir;
    logic [1:0] raddr;
    logic       ready;
    logic       v;
    logic [1:0] instr, ipc, maddr;
    logic       h;
    logic [7:0] cnt;
  } vec_t;

  vec_t tab_a[24];
  vec_t tab_b[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural reference: occupancy flag for the one-entry stage, mode flags.
  int         m_pc[2], m_cnt[2];
  int         m_max[2] = '{0, 3};
  bit         m_has[2], m_run[2], m_drain[2], m_halt[2];
  logic [1:0] m_instr[2], m_ipc[2];

  function automatic vec_t mk(input bit r, input bit s, input bit hq, input bit rd,
                              input int ra, input bit rdy, input bit v, input int ins,
                              input int ip, input int ma, input bit hl, input int cn);
    vec_t t;
    t.rst_n = r; t.start = s; t.halt = hq; t.redir = rd; t.raddr = 2'(ra); t.ready = rdy;
    t.v = v; t.instr = 2'(ins); t.ipc = 2'(ip); t.maddr = 2'(ma); t.h = hl; t.cnt = 8'(cn);
    return t;
  endfunction

  function automatic logic [15:0] exp_of(input vec_t t);
    return {t.v, t.instr, t.ipc, t.maddr, t.h, t.cnt};
  endfunction

  function automatic logic [15:0] act_a();
    return {a_valid, a_instr, a_ipc, a_maddr, a_halted, a_cnt};
  endfunction

  function automatic logic [15:0] act_b();
    return {b_valid, b_instr, b_ipc, b_maddr, b_halted, b_cnt};
  endfunction

  function automatic logic [15:0] model_out(input int d);
    return {m_has[d], m_instr[d], m_ipc[d], 2'(m_pc[d]), m_halt[d], 8'(m_cnt[d])};
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got v/instr/pc/addr/halted/cnt=%b/%b/%b/%b/%b/%0d want %b/%b/%b/%b/%b/%0d",
               name, idx, act[15], act[14:13], act[12:11], act[10:9], act[8], act[7:0],
               exp[15], exp[14:13], exp[12:11], exp[10:9], exp[8], exp[7:0]);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n = t.rst_n; start = t.start; halt_req = t.halt; redir = t.redir;
    raddr = t.raddr; ready = t.ready;
  endtask

  // Advances the reference by one clock using the inputs currently driven.
  task automatic model_step(input int d);
    bit pre_has, xfer, bud;
    if (!rst_n) begin
      m_pc[d] = 0; m_cnt[d] = 0; m_has[d] = 1'b0; m_run[d] = 1'b0;
      m_drain[d] = 1'b0; m_halt[d] = 1'b0; m_instr[d] = 2'd0; m_ipc[d] = 2'd0;
      return;
    end
    pre_has = m_has[d];
    xfer    = pre_has && ready;
    bud     = 1'b0;
    if (redir) begin
      m_has[d] = 1'b0;
      m_pc[d]  = int'(raddr);
    end else if (xfer) begin
      m_has[d] = 1'b0;
      if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
      bud = m_run[d] && (m_max[d] != 0) && (m_cnt[d] == m_max[d]);
    end
    if (m_run[d]) begin
      if (halt_req || bud) begin
        m_run[d] = 1'b0; m_drain[d] = 1'b1;
      end else if (!redir && !m_has[d]) begin
        m_has[d] = 1'b1; m_instr[d] = mem[m_pc[d]]; m_ipc[d] = 2'(m_pc[d]);
        m_pc[d] = (m_pc[d] + 1) % 4;
      end
    end else if (m_drain[d]) begin
      if (!pre_has || ready) begin
        m_drain[d] = 1'b0; m_halt[d] = 1'b1;
      end
    end else if (start && !halt_req) begin
      m_run[d] = 1'b1; m_halt[d] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redir = 1'b0; raddr = 2'd0; ready = 1'b0;
    mem[0] = 2'b10; mem[1] = 2'b01; mem[2] = 2'b11; mem[3] = 2'b00;

    //             rst st hq rd ra rdy   v ins ip ma h cnt
    tab_a[0]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tab_a[1]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tab_a[2]  = mk(1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    tab_a[3]  = mk(1, 0, 0, 0, 0, 1,   1, 2, 0, 1, 0, 0);
    tab_a[4]  = mk(1, 0, 0, 0, 0, 1,   1, 1, 1, 2, 0, 1);
    tab_a[5]  = mk(1, 0, 0, 0, 0, 1,   1, 3, 2, 3, 0, 2);
    tab_a[6]  = mk(1, 0, 0, 0, 0, 0,   1, 3, 2, 3, 0, 2);
    tab_a[7]  = mk(1, 0, 0, 0, 0, 0,   1, 3, 2, 3, 0, 2);
    tab_a[8]  = mk(1, 0, 0, 0, 0, 0,   1, 3, 2, 3, 0, 2);
    tab_a[9]  = mk(1, 0, 0, 0, 0, 1,   1, 0, 3, 0, 0, 3);
    tab_a[10] = mk(1, 0, 0, 0, 0, 1,   1, 2, 0, 1, 0, 4);
    tab_a[11] = mk(1, 0, 0, 0, 0, 1,   1, 1, 1, 2, 0, 5);
    tab_a[12] = mk(1, 0, 0, 1, 1, 0,   0, 1, 1, 1, 0, 5);
    tab_a[13] = mk(1, 0, 0, 0, 0, 0,   1, 1, 1, 2, 0, 5);
    tab_a[14] = mk(1, 0, 1, 0, 0, 0,   1, 1, 1, 2, 0, 5);
    tab_a[15] = mk(1, 0, 0, 0, 0, 0,   1, 1, 1, 2, 0, 5);
    tab_a[16] = mk(1, 0, 0, 0, 0, 1,   0, 1, 1, 2, 1, 6);
    tab_a[17] = mk(1, 0, 0, 0, 0, 1,   0, 1, 1, 2, 1, 6);
    tab_a[18] = mk(1, 1, 0, 0, 0, 1,   0, 1, 1, 2, 0, 6);
    tab_a[19] = mk(1, 0, 0, 0, 0, 1,   1, 3, 2, 3, 0, 6);
    tab_a[20] = mk(1, 0, 0, 0, 0, 1,   1, 0, 3, 0, 0, 7);
    tab_a[21] = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    tab_a[22] = mk(1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    tab_a[23] = mk(1, 0, 0, 0, 0, 1,   1, 2, 0, 1, 0, 0);

    tab_b[0]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tab_b[1]  = mk(1, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    tab_b[2]  = mk(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    tab_b[3]  = mk(1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    tab_b[4]  = mk(1, 0, 0, 0, 0, 1,   1, 2, 0, 1, 0, 0);
    tab_b[5]  = mk(1, 0, 0, 0, 0, 1,   1, 1, 1, 2, 0, 1);
    tab_b[6]  = mk(1, 0, 0, 0, 0, 1,   1, 3, 2, 3, 0, 2);
    tab_b[7]  = mk(1, 0, 0, 0, 0, 1,   0, 3, 2, 3, 0, 3);
    tab_b[8]  = mk(1, 0, 0, 0, 0, 1,   0, 3, 2, 3, 1, 3);
    tab_b[9]  = mk(1, 0, 0, 0, 0, 1,   0, 3, 2, 3, 1, 3);

    for (int i = 0; i < 24; i++) begin
      drive(tab_a[i]);
      @(posedge clk); #1;
      check("vec_a", i, act_a(), exp_of(tab_a[i]));
    end

    for (int i = 0; i < 10; i++) begin
      drive(tab_b[i]);
      @(posedge clk); #1;
      check("vec_b", i, act_b(), exp_of(tab_b[i]));
    end

    for (int i = 0; i < 4; i++) mem[i] = 2'($urandom_range(0, 3));

    for (int c = 0; c < 800; c++) begin
      rst_n    = (c == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
      start    = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 15) == 0);
      redir    = ($urandom_range(0, 9) == 0);
      raddr    = 2'($urandom_range(0, 3));
      ready    = ($urandom_range(0, 3) != 0);
      model_step(0);
      model_step(1);
      @(posedge clk); #1;
      check("rand_a", c, act_a(), model_out(0));
      check("rand_b", c, act_b(), model_out(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
Sequences the 2-bit x 4-deep instruction memory. It owns the program counter and drives the memory address. It registers the combinational read data into a one-entry output stage and hands each instruction to decode over a valid/ready handshake. It also supports start, halt, redirect (jump) and an optional fetch budget, and sits between the instruction memory and the decode stage of the processor.

Parameters:
ADDR_W, 2, memory address width; PC wraps modulo 2^ADDR_W
DATA_W, 2, instruction width (matches memory word)
MAX_FETCH, 0, auto-halt after this many accepted instructions; 0 = unlimited
CNT_W, 8, width of fetch_count

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  pulse; leave IDLE/HALTED and begin fetching at current pc
halt_req  in  1  pulse; stop issuing new fetches
redirect_valid  in  1  load pc from redirect_addr, flush output stage
redirect_addr  in  ADDR_W  jump target
mem_addr  out  ADDR_W  address to instruction memory (= pc register)
mem_data  in  DATA_W  combinational read data for mem_addr
instr_valid  out  1  output stage holds an instruction
instr_ready  in  1  decode accepts this cycle
instr  out  DATA_W  instruction
instr_pc  out  ADDR_W  address the instruction came from
halted  out  1  high in HALTED state
fetch_count  out  CNT_W  accepted transfers since reset, saturating

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, pc=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, halted=0, fetch_count=0. Reset mid-transfer discards the output stage.
- States: IDLE, FETCH, DRAIN, HALTED.
  - IDLE: start -> FETCH.
  - FETCH: halt_req, or reaching the budget (below) -> DRAIN.
  - DRAIN: instr_valid==0 or a transfer occurs -> HALTED.
  - HALTED: start -> FETCH.
- Load rule (FETCH only): load = !instr_valid || instr_ready. On load: instr<=mem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1 mod 2^ADDR_W (3 -> 0, no flag).
- Latency: the word at address A is visible on instr one cycle after mem_addr==A. Back-to-back throughput is 1 instruction per cycle while instr_ready=1.
- Stall: instr_valid && !instr_ready -> instr, instr_pc and pc are held stable.
- Transfer: instr_valid && instr_ready, counted in fetch_count (saturates at 2^CNT_W-1). In non-FETCH states, a transfer clears instr_valid.
- Redirect (any state): pc<=redirect_addr, instr_valid<=0 (held instruction dropped, not counted), no load that cycle. The first word from the target appears 2 cycles after the redirect cycle. In IDLE/HALTED, redirect only updates pc.
- Budget: with MAX_FETCH!=0, the transfer that makes the count of accepted instructions equal MAX_FETCH also forces FETCH -> DRAIN. No further loads occur.
- halted=1 only in HALTED. Leaving via start resumes at the current pc.
- Simultaneous events:
  - halt_req wins over start in the same cycle.
  - redirect + halt_req: pc is updated and the state goes to DRAIN; the output stage is flushed, so the state reaches HALTED next cycle.
  - start while in FETCH/DRAIN is ignored.
- mem_addr is driven directly from the pc register, with no combinational path from inputs.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN, HALTED);
  - ADDR_W/DATA_W defaults;
  - a pc increment helper function.
- One natural sub-module: fetch_out_stage, the one-entry valid/ready pipeline register holding instr/instr_pc, with a load and flush interface.
- The FSM, pc and counter stay in the top module.

Test Plan:
- Memory = {10,01,11,00}; reset, start, instr_ready=1 -> instr 10,01,11,00,10 with instr_pc 0,1,2,3,0 on consecutive cycles; first valid 2 cycles after start; fetch_count increments each cycle.
- Hold instr_ready=0 for 3 cycles while instr=11 (pc=2) -> instr/instr_pc stable at 11/2, mem_addr stays 3; release -> 00 follows next cycle with no duplicate or skip.
- redirect_valid with redirect_addr=1 while instr=01 is valid and not ready -> instr_valid=0 next cycle; 2 cycles after redirect instr=01, instr_pc=1; fetch_count unchanged by the flushed word.
- halt_req with instr_ready=0 -> DRAIN keeps the word valid; after instr_ready=1 -> HALTED, halted=1, no new valid; start -> fetching resumes from the saved pc.
- MAX_FETCH=3 -> exactly 3 transfers (10,01,11), then halted=1, fetch_count=3; halt_req+start in the same cycle in IDLE -> stays IDLE.
- rst_n=0 mid-stream with instr_valid=1 -> next cycle all outputs are 0, state IDLE; start refetches from address 0.
